wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter that drives the register file's single write port. It accepts results from the load/store unit (mem) and the ALU over valid/ready handshakes, and queues them in order in a small FIFO. It retires one result per cycle as `we`/`waddr`/`wdata`. It also exposes two lookup ports so operand fetch can forward results that are still queued.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_W, 5, register address width (matches `RegAddrBus`)
- DATA_W, 32, register data width (matches `RegBus`)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset; sampled on posedge clk
- mem_valid  in  1  load/store result valid
- mem_ready  out  1  arbiter accepts mem result this cycle
- mem_waddr  in  ADDR_W  destination register
- mem_wdata  in  DATA_W  result data
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  arbiter accepts ALU result this cycle
- alu_waddr  in  ADDR_W  destination register
- alu_wdata  in  DATA_W  result data
- we  out  1  register-file write enable
- waddr  out  ADDR_W  register-file write address
- wdata  out  DATA_W  register-file write data
- fwd_raddr1, fwd_raddr2  in  ADDR_W  lookup addresses
- fwd_hit1, fwd_hit2  out  1  lookup address matches a queued entry
- fwd_data1, fwd_data2  out  DATA_W  data of the youngest matching entry

## Operation
- Circular FIFO: head pointer, tail pointer, count.
  - Pointer width: log2(DEPTH).
  - Count width: log2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
- Handshake: a source transfer occurs in a cycle where valid && ready are both high at the posedge.
- free = DEPTH − count, evaluated on the registered count. The current cycle's pop is not credited, so there is no combinational path from the write port to the ready outputs.
- mem_ready = !rst && free ≥ 1.
- alu_ready = !rst && (free ≥ 2 || (free == 1 && !mem_valid)).
  - mem has priority on the last slot.
  - alu_ready must not depend on alu_valid.
- Enqueue order when both sources transfer in the same cycle:
  - mem entry first (at tail), ALU entry second (at tail+1).
  - tail advances by the number of entries enqueued.
- A transfer with waddr == 0 is accepted (ready honoured) but not enqueued. It consumes no slot and never reaches the write port.
- Dequeue: whenever count ≠ 0, the head entry is presented on the write port and popped at that posedge.
  - The register file never stalls, so one entry retires per cycle.
- Write-port outputs come combinationally from the head entry:
  - we = (count ≠ 0).
  - waddr and wdata = head entry fields.
  - When empty: waddr = 0, wdata = 0.
- Count update: count_next = count + pushes − pop, where pushes ∈ {0,1,2} and pop ∈ {0,1}. Count must never exceed DEPTH.
- Forwarding, evaluated combinationally over the valid entries only:
  - fwd_hitN = 1 if any queued entry has waddr == fwd_raddrN and fwd_raddrN ≠ 0.
  - fwd_dataN = data of the youngest such entry (closest to tail); 0 on a miss.
  - The head entry counts as queued. The requester handles same-cycle writes through the register file's own bypass.
  - Entries being pushed this cycle are not visible until the next cycle.

## Timing
- Reset, while rst is high and at the posedge it is sampled:
  - count, head and tail return to 0; FIFO contents are don't-care.
  - Outputs forced: we = 0, waddr = 0, wdata = 0, mem_ready = 0, alu_ready = 0, fwd_hit* = 0, fwd_data* = 0.
- Reset mid-operation: queued entries are discarded with no write issued. A handshake presented in the reset cycle is not accepted.
- Latency: a result transferred at posedge N appears on we/waddr/wdata in cycle N+1 if the FIFO was empty, and is written at posedge N+1.
  - Each older queued entry adds one cycle.
- Throughput: one retire per cycle. Sustained two-source input fills the FIFO, after which readies throttle it.
- Full (count == DEPTH): both readies are 0, and the pop still occurs, so the readies reassert the next cycle.
- Simultaneous push and pop on a single free slot: the push is accepted, because free is computed from the registered count.
- Ordering across sources: same cycle is mem before ALU; across cycles it is strict arrival order. Two queued writes to the same register therefore commit oldest-first.

## Test plan
- Reset, then idle:
  - we = 0 and both readies = 1 from the first cycle after reset.
  - Raise rst with 3 entries queued → count = 0 next cycle, no we pulse.
- Single ALU push of x5 = 0x1234 at cycle N → cycle N+1 shows we = 1, waddr = 5, wdata = 0x1234; cycle N+2 shows we = 0.
- Same-cycle mem x3 = 0xAAAA and ALU x3 = 0xBBBB:
  - Writes retire x3 = 0xAAAA then x3 = 0xBBBB on consecutive cycles.
  - fwd_raddr1 = 3 in the cycle between the two writes → hit, data 0xBBBB.
- Fill with DEPTH = 4: drive both sources valid every cycle → count never exceeds 4, alu_ready = 0 whenever free ≤ 1 and mem_valid = 1, and every accepted entry is written exactly once, in order.
- x0 filtering: ALU push to x0 with data 0xDEAD → alu_ready handshake completes, count unchanged, no we pulse, fwd with raddr 0 → hit = 0.
- Pointer wrap: 10 back-to-back single pushes with distinct data → 10 writes in order with correct data across the wrap of head and tail.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: queues mem/ALU results in arrival order and retires one per
// cycle to the register file write port, with two forwarding lookups into the queue.
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0] alu_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] fwd_raddr1,
  input  logic [ADDR_W-1:0] fwd_raddr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic [CNT_W-1:0]  w_free;
  logic              w_push_mem;
  logic              w_push_alu;
  logic              w_pop;
  logic [PTR_W-1:0]  w_alu_slot;
  logic [DATA_W:0]   w_fwd1;
  logic [DATA_W:0]   w_fwd2;

  // Readies use only the registered count, so the write port never feeds them.
  assign w_free    = CNT_W'(DEPTH) - r_count;
  assign mem_ready = !rst && (w_free != '0);
  assign alu_ready = !rst && ((w_free >= CNT_W'(2)) || ((w_free == CNT_W'(1)) && !mem_valid));

  assign w_push_mem = mem_valid && mem_ready && (mem_waddr != '0);
  assign w_push_alu = alu_valid && alu_ready && (alu_waddr != '0);
  assign w_pop      = (r_count != '0);
  assign w_alu_slot = r_tail + PTR_W'(w_push_mem);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_push_mem) + PTR_W'(w_push_alu);
      r_count <= r_count + CNT_W'(w_push_mem) + CNT_W'(w_push_alu) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_mem) begin
      r_addr[r_tail] <= mem_waddr;
      r_data[r_tail] <= mem_wdata;
    end
    if (w_push_alu) begin
      r_addr[w_alu_slot] <= alu_waddr;
      r_data[w_alu_slot] <= alu_wdata;
    end
  end

  assign we    = !rst && w_pop;
  assign waddr = we ? r_addr[r_head] : '0;
  assign wdata = we ? r_data[r_head] : '0;

  // Scan oldest to youngest so the last match seen is the youngest one.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] raddr);
    logic [PTR_W-1:0] idx;
    fwd_lookup = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (raddr != '0) && (r_addr[idx] == raddr))
        fwd_lookup = {1'b1, r_data[idx]};
    end
  endfunction

  always_comb begin
    w_fwd1 = '0;
    w_fwd2 = '0;
    if (!rst) begin
      w_fwd1 = fwd_lookup(fwd_raddr1);
      w_fwd2 = fwd_lookup(fwd_raddr2);
    end
  end

  assign fwd_hit1  = w_fwd1[DATA_W];
  assign fwd_data1 = w_fwd1[DATA_W-1:0];
  assign fwd_hit2  = w_fwd2[DATA_W];
  assign fwd_data2 = w_fwd2[DATA_W-1:0];

endmodule
